rf_wb_arbiter: RTL and testbench

Shares the single register-file write port between the in-order writeback (WB) stage and the multi-cycle mul/div unit (MDU). The in-order WB path has priority. MDU results are buffered in a small FIFO and drained on free port cycles. Buffered results overwritten by younger pipeline writes are squashed. A bounded-starvation counter briefly stalls the pipeline so the MDU result drains.

---
 rtl/rf_wb_arbiter.sv | 159 +++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Shares the single register-file write port between the in-order WB stage
// (priority) and the multi-cycle MDU. MDU results wait in a small FIFO and
// drain on free port cycles; entries overwritten by a younger pipe write are
// killed in place. After STARVE_LIMIT consecutive denied cycles the pipeline
// is stalled for one cycle (FORCE) so the head drains.
//
// Ports:
//   clk_i, rst_ni                       clock, async active-low reset
//   pipe_we_i/pipe_dest_i/pipe_wdata_i  WB stage write request
//   mdu_valid_i/mdu_dest_i/mdu_wdata_i  MDU result, accepted when mdu_ready_o
//   mdu_ready_o                         FIFO not full
//   rf_we_o/rf_waddr_o/rf_wdata_o       register-file write port (combinational)
//   stall_o                             registered, high only in FORCE
//   pending_o                           FIFO occupancy (live + killed entries)
module rf_wb_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             pipe_we_i,
  input  logic [ADDR_WIDTH-1:0]            pipe_dest_i,
  input  logic [DATA_WIDTH-1:0]            pipe_wdata_i,
  input  logic                             mdu_valid_i,
  input  logic [ADDR_WIDTH-1:0]            mdu_dest_i,
  input  logic [DATA_WIDTH-1:0]            mdu_wdata_i,
  output logic                             mdu_ready_o,
  output logic                             rf_we_o,
  output logic [ADDR_WIDTH-1:0]            rf_waddr_o,
  output logic [DATA_WIDTH-1:0]            rf_wdata_o,
  output logic                             stall_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  pending_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

  typedef enum logic {IDLE, FORCE} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  dest_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]  live_q, live_d;
  logic [PTR_W-1:0]       rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [STV_W-1:0]       starve_q, starve_d, starve_inc;
  logic                   full, empty, head_live, pipe_commit;
  logic                   push, pop, head_wr;

  always_comb begin
    full        = (count_q == FULL_CNT);
    empty       = (count_q == '0);
    head_live   = !empty && live_q[rd_ptr_q];
    pipe_commit = pipe_we_i && (pipe_dest_i != '0) && (state_q == IDLE);
    push        = mdu_valid_i && !full;
    starve_inc  = starve_q + STV_W'(1);

    pop      = 1'b0;
    head_wr  = 1'b0;
    state_d  = state_q;
    starve_d = starve_q;

    case (state_q)
      IDLE: begin
        // Killed heads leave without the port even while the pipe writes.
        if (!empty) begin
          if (!head_live) begin
            pop = 1'b1;
          end else if (!pipe_commit) begin
            pop     = 1'b1;
            head_wr = 1'b1;
          end
        end
        if (empty || head_wr) begin
          starve_d = '0;
        end else if (head_live && pipe_commit) begin
          if (starve_inc == STV_MAX) begin
            starve_d = '0;
            state_d  = FORCE;
          end else begin
            starve_d = starve_inc;
          end
        end
      end
      FORCE: begin
        pop      = !empty;
        head_wr  = head_live;
        starve_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rf_we_o    = pipe_commit;
    rf_waddr_o = pipe_dest_i;
    rf_wdata_o = pipe_wdata_i;
    if (head_wr) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = dest_q[rd_ptr_q];
      rf_wdata_o = data_q[rd_ptr_q];
    end

    // Younger pipe write supersedes any buffered result to the same register;
    // a result pushed in the same cycle is older than that write too.
    live_d = live_q;
    if (pipe_commit) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        if (dest_q[PTR_W'(i)] == pipe_dest_i) live_d[PTR_W'(i)] = 1'b0;
      end
    end
    if (push) begin
      live_d[wr_ptr_q] = (mdu_dest_i != '0) &&
                         !(pipe_commit && (pipe_dest_i == mdu_dest_i));
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      live_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      live_q   <= live_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
    end
  end

  // Payload needs no reset: occupancy and live bits qualify every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      dest_q[wr_ptr_q] <= mdu_dest_i;
      data_q[wr_ptr_q] <= mdu_wdata_i;
    end
  end

  assign mdu_ready_o = !full;
  assign stall_o     = (state_q == FORCE);
  assign pending_o   = count_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter
// Directed bench for rf_wb_arbiter. Every expected register-file write is
// queued (cycle, addr, data) before its stimulus is driven; a negedge monitor
// pops and compares each observed write. Status outputs are checked directly.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        pipe_we_i;
  logic [4:0]  pipe_dest_i;
  logic [31:0] pipe_wdata_i;
  logic        mdu_valid_i;
  logic [4:0]  mdu_dest_i;
  logic [31:0] mdu_wdata_i;
  logic        mdu_ready_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        stall_o;
  logic [1:0]  pending_o;

  rf_wb_arbiter #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (5),
    .FIFO_DEPTH  (2),
    .STARVE_LIMIT(4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .pipe_we_i   (pipe_we_i),
    .pipe_dest_i (pipe_dest_i),
    .pipe_wdata_i(pipe_wdata_i),
    .mdu_valid_i (mdu_valid_i),
    .mdu_dest_i  (mdu_dest_i),
    .mdu_wdata_i (mdu_wdata_i),
    .mdu_ready_o (mdu_ready_o),
    .rf_we_o     (rf_we_o),
    .rf_waddr_o  (rf_waddr_o),
    .rf_wdata_o  (rf_wdata_o),
    .stall_o     (stall_o),
    .pending_o   (pending_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  int unsigned rdy4 [10] = '{1, 1, 0, 0, 0, 0, 1, 0, 1, 1};
  int unsigned pend4[10] = '{0, 1, 2, 2, 2, 2, 1, 2, 1, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic expect_wr(input int unsigned c, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.cyc  = c;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  // Applies one cycle of stimulus just after the rising edge and returns at
  // the following falling edge, where outputs are sampled.
  task automatic step(input logic pwe, input logic [4:0] pd, input logic [31:0] pw,
                      input logic mv, input logic [4:0] md, input logic [31:0] mw);
    @(posedge clk);
    #1;
    pipe_we_i    = pwe;
    pipe_dest_i  = pd;
    pipe_wdata_i = pw;
    mdu_valid_i  = mv;
    mdu_dest_i   = md;
    mdu_wdata_i  = mw;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  always @(negedge clk) begin
    if (rf_we_o === 1'b1) begin
      if (sb.size() == 0) begin
        check($sformatf("unexp_we_addr%0d", rf_waddr_o), 64'(rf_we_o), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wr_cycle", 64'(cyc), 64'(e.cyc));
        check("wr_addr", 64'(rf_waddr_o), 64'(e.addr));
        check("wr_data", 64'(rf_wdata_o), 64'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni       = 1'b0;
    pipe_we_i    = 1'b0;
    pipe_dest_i  = '0;
    pipe_wdata_i = '0;
    mdu_valid_i  = 1'b0;
    mdu_dest_i   = '0;
    mdu_wdata_i  = '0;

    // Reset state; pipe commits still reach the port while in reset.
    expect_wr(cyc + 1, 5'd4, 32'h0000_0044);
    step(1'b1, 5'd4, 32'h0000_0044, 1'b0, 5'd0, 32'd0);
    check("rst_stall", 64'(stall_o), 64'd0);
    check("rst_pending", 64'(pending_o), 64'd0);
    check("rst_ready", 64'(mdu_ready_o), 64'd1);
    rst_ni = 1'b1;
    idle();

    // Idle pipe: MDU result written one cycle after the push edge.
    expect_wr(cyc + 2, 5'd5, 32'hDEAD_BEEF);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    check("s1_pend0", 64'(pending_o), 64'd0);
    idle();
    check("s1_pend1", 64'(pending_o), 64'd1);
    idle();
    check("s1_pend_drained", 64'(pending_o), 64'd0);

    // Starvation: four denied cycles, then one FORCE cycle writes dest 7.
    for (int k = 0; k < 7; k++) begin
      if (k == 5) expect_wr(cyc + 1, 5'd7, 32'h0000_0077);
      else        expect_wr(cyc + 1, 5'd3, 32'h3000_0000 + 32'(k));
      step(1'b1, 5'd3, 32'h3000_0000 + 32'(k), k == 0, 5'd7, 32'h0000_0077);
      check($sformatf("s2_stall_k%0d", k), 64'(stall_o), (k == 5) ? 64'd1 : 64'd0);
      if (k == 5) check("s2_pend_force", 64'(pending_o), 64'd1);
    end
    check("s2_pend_after", 64'(pending_o), 64'd0);

    // Kill: buffered dest 9 superseded by a pipe write, then popped silently.
    expect_wr(cyc + 1, 5'd3, 32'h0000_0333);
    step(1'b1, 5'd3, 32'h0000_0333, 1'b1, 5'd9, 32'h0000_0099);
    expect_wr(cyc + 1, 5'd9, 32'h0000_0011);
    step(1'b1, 5'd9, 32'h0000_0011, 1'b0, 5'd0, 32'd0);
    expect_wr(cyc + 1, 5'd4, 32'h0000_0444);
    step(1'b1, 5'd4, 32'h0000_0444, 1'b0, 5'd0, 32'd0);
    check("s3_pend_killed", 64'(pending_o), 64'd1);
    idle();
    check("s3_pend_after", 64'(pending_o), 64'd0);
    idle();

    // Full FIFO refuses C until the FORCE pop edge.
    for (int k = 0; k < 10; k++) begin
      if (k <= 4 || k == 6) expect_wr(cyc + 1, 5'd3, 32'h4000_0000 + 32'(k));
      else if (k == 5)      expect_wr(cyc + 1, 5'd10, 32'h0000_00A0);
      else if (k == 7)      expect_wr(cyc + 1, 5'd11, 32'h0000_00B0);
      else if (k == 8)      expect_wr(cyc + 1, 5'd12, 32'h0000_00C0);
      step(k <= 6, 5'd3, 32'h4000_0000 + 32'(k), k <= 6,
           (k == 0) ? 5'd10 : (k == 1) ? 5'd11 : 5'd12,
           (k == 0) ? 32'h0000_00A0 : (k == 1) ? 32'h0000_00B0 : 32'h0000_00C0);
      check($sformatf("s4_ready_k%0d", k), 64'(mdu_ready_o), 64'(rdy4[k]));
      check($sformatf("s4_pend_k%0d", k), 64'(pending_o), 64'(pend4[k]));
      check($sformatf("s4_stall_k%0d", k), 64'(stall_o), (k == 5) ? 64'd1 : 64'd0);
    end

    // x0: MDU x0 entry dropped; pending head drains in the pipe's x0 cycle.
    expect_wr(cyc + 1, 5'd3, 32'h0000_0500);
    step(1'b1, 5'd3, 32'h0000_0500, 1'b1, 5'd0, 32'h0000_00E0);
    expect_wr(cyc + 1, 5'd3, 32'h0000_0501);
    step(1'b1, 5'd3, 32'h0000_0501, 1'b1, 5'd13, 32'h0000_00D0);
    check("s5_pend_swap", 64'(pending_o), 64'd1);
    expect_wr(cyc + 1, 5'd13, 32'h0000_00D0);
    step(1'b1, 5'd0, 32'h0000_0055, 1'b0, 5'd0, 32'd0);
    step(1'b1, 5'd0, 32'h0000_0056, 1'b0, 5'd0, 32'd0);
    check("s5_x0_we", 64'(rf_we_o), 64'd0);
    check("s5_pend_after", 64'(pending_o), 64'd0);

    // Same-cycle push and pipe commit to one dest: entry enters killed.
    expect_wr(cyc + 1, 5'd14, 32'h0000_00EE);
    step(1'b1, 5'd14, 32'h0000_00EE, 1'b1, 5'd14, 32'h0000_00F0);
    idle();
    check("s6_pend_killed", 64'(pending_o), 64'd1);
    idle();
    check("s6_pend_after", 64'(pending_o), 64'd0);

    // Reset while in FORCE with two live entries.
    for (int k = 0; k < 5; k++) begin
      expect_wr(cyc + 1, 5'd3, 32'h6000_0000 + 32'(k));
      step(1'b1, 5'd3, 32'h6000_0000 + 32'(k), k <= 1,
           (k == 0) ? 5'd20 : 5'd21, (k == 0) ? 32'h0000_0020 : 32'h0000_0021);
    end
    @(posedge clk);
    #1;
    check("s7_pre_stall", 64'(stall_o), 64'd1);
    check("s7_pre_pend", 64'(pending_o), 64'd2);
    pipe_we_i   = 1'b0;
    mdu_valid_i = 1'b0;
    rst_ni      = 1'b0;
    #1;
    check("s7_rst_stall", 64'(stall_o), 64'd0);
    check("s7_rst_pend", 64'(pending_o), 64'd0);
    check("s7_rst_ready", 64'(mdu_ready_o), 64'd1);
    @(negedge clk);
    idle();
    idle();
    rst_ni = 1'b1;
    for (int k = 0; k < 4; k++) idle();
    check("s7_pend_after", 64'(pending_o), 64'd0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
